// File: rtl/fifo2axi_repack.sv
// Rebuilds 256-bit AXI4-Stream beats from the cropped 202-bit SRAM word stream
// (header word, then 192-bit payload words rotating through phases 1..4).
module fifo2axi_repack #(
  parameter int TDATA_WIDTH        = 32,
  parameter int TUSER_WIDTH        = 16,
  parameter int CROPPED_DATA_WIDTH = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [8*CROPPED_DATA_WIDTH+9:0]   din,
  input  logic                              din_valid,
  output logic                              din_ready,
  output logic [8*TDATA_WIDTH-1:0]          m_tdata,
  output logic [TDATA_WIDTH-1:0]            m_tstrb,
  output logic [8*TUSER_WIDTH-1:0]          m_tuser,
  output logic                              m_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              err_phase
);

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_P1     = 3'd1,
    ST_P2     = 3'd2,
    ST_P3     = 3'd3,
    ST_P4     = 3'd4,
    ST_RESYNC = 3'd5
  } state_t;

  function automatic logic [31:0] last_strb(input logic [4:0] n);
    logic [31:0] s;
    if (n == 5'd0) begin
      s = 32'hFFFF_FFFF;
    end else begin
      s = (32'h1 << n) - 32'h1;
    end
    return s;
  endfunction

  function automatic logic [255:0] apply_strb(input logic [255:0] d, input logic [31:0] strb);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = strb[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;
  logic [191:0]   acc_r;
  logic [191:0]   acc_nxt_s;
  logic [127:0]   tuser_r;
  logic           pend_r;
  logic [255:0]   pend_data_r;
  logic [31:0]    pend_strb_r;

  logic [191:0]   payload_s;
  logic [4:0]     nbytes_s;
  logic [2:0]     phase_s;
  logic           tlast_in_s;
  logic           unused_s;
  logic           out_free_s;
  logic           fire_s;
  logic [31:0]    lstrb_s;

  logic           emit_s;
  logic           emit_last_s;
  logic [255:0]   emit_raw_s;
  logic [255:0]   emit_data_s;
  logic [31:0]    emit_strb_s;
  logic           pend_set_s;
  logic [255:0]   pend_raw_s;
  logic [255:0]   pend_data_s;
  logic           err_s;
  logic           tuser_ld_s;

  assign payload_s  = din[201:10];
  assign nbytes_s   = din[9:5];
  assign phase_s    = din[4:2];
  assign tlast_in_s = din[1];
  assign unused_s   = din[0];

  // A pending tail beat blocks input so the word stream cannot overtake it.
  assign out_free_s = ~m_tvalid | m_tready;
  assign din_ready  = out_free_s & ~pend_r;
  assign fire_s     = din_valid & din_ready;
  assign lstrb_s    = last_strb(nbytes_s);

  // Next-state, beat assembly and phase checking for the accepted word.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    emit_s      = 1'b0;
    emit_last_s = 1'b0;
    emit_raw_s  = 256'h0;
    pend_set_s  = 1'b0;
    pend_raw_s  = 256'h0;
    err_s       = 1'b0;
    tuser_ld_s  = 1'b0;
    if (fire_s) begin
      case (state_r)
        ST_HDR, ST_RESYNC: begin
          if ((phase_s == 3'd0) && !tlast_in_s) begin
            tuser_ld_s  = 1'b1;
            state_nxt_s = ST_P1;
          end else if ((phase_s == 3'd0) || (state_r == ST_HDR)) begin
            err_s       = 1'b1;
            state_nxt_s = ST_RESYNC;
          end else begin
            state_nxt_s = ST_RESYNC;
          end
        end
        ST_P1: begin
          if (phase_s != 3'd1) begin
            err_s       = 1'b1;
            state_nxt_s = ST_RESYNC;
          end else if (tlast_in_s) begin
            emit_s      = 1'b1;
            emit_last_s = 1'b1;
            emit_raw_s  = {64'h0, payload_s};
            state_nxt_s = ST_HDR;
          end else begin
            acc_nxt_s   = payload_s;
            state_nxt_s = ST_P2;
          end
        end
        ST_P2: begin
          if (phase_s != 3'd2) begin
            err_s       = 1'b1;
            state_nxt_s = ST_RESYNC;
          end else begin
            emit_s     = 1'b1;
            emit_raw_s = {payload_s[63:0], acc_r};
            if (tlast_in_s) begin
              pend_set_s  = 1'b1;
              pend_raw_s  = {128'h0, payload_s[191:64]};
              state_nxt_s = ST_HDR;
            end else begin
              acc_nxt_s   = {64'h0, payload_s[191:64]};
              state_nxt_s = ST_P3;
            end
          end
        end
        ST_P3: begin
          if (phase_s != 3'd3) begin
            err_s       = 1'b1;
            state_nxt_s = ST_RESYNC;
          end else begin
            emit_s     = 1'b1;
            emit_raw_s = {payload_s[127:0], acc_r[127:0]};
            if (tlast_in_s) begin
              pend_set_s  = 1'b1;
              pend_raw_s  = {192'h0, payload_s[191:128]};
              state_nxt_s = ST_HDR;
            end else begin
              acc_nxt_s   = {128'h0, payload_s[191:128]};
              state_nxt_s = ST_P4;
            end
          end
        end
        ST_P4: begin
          if (phase_s != 3'd4) begin
            err_s       = 1'b1;
            state_nxt_s = ST_RESYNC;
          end else begin
            emit_s      = 1'b1;
            emit_last_s = tlast_in_s;
            emit_raw_s  = {payload_s, acc_r[63:0]};
            state_nxt_s = tlast_in_s ? ST_HDR : ST_P1;
          end
        end
        default: begin
          err_s       = 1'b1;
          state_nxt_s = ST_RESYNC;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    emit_strb_s = emit_last_s ? lstrb_s : 32'hFFFF_FFFF;
    emit_data_s = apply_strb(emit_raw_s, emit_strb_s);
    pend_data_s = apply_strb(pend_raw_s, lstrb_s);
  end

  // Sequencer state, header tuser, pending tail beat and registered AXI outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_HDR;
      acc_r       <= 192'h0;
      tuser_r     <= 128'h0;
      pend_r      <= 1'b0;
      pend_data_r <= 256'h0;
      pend_strb_r <= 32'h0;
      m_tdata     <= 256'h0;
      m_tstrb     <= 32'h0;
      m_tuser     <= 128'h0;
      m_tlast     <= 1'b0;
      m_tvalid    <= 1'b0;
      err_phase   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      err_phase <= err_s;
      if (tuser_ld_s) begin
        tuser_r <= payload_s[127:0];
      end
      // Word-driven beats and the pending tail never coincide: fire needs ~pend_r.
      if (emit_s) begin
        m_tvalid <= 1'b1;
        m_tdata  <= emit_data_s;
        m_tstrb  <= emit_strb_s;
        m_tlast  <= emit_last_s;
        m_tuser  <= tuser_r;
      end else if (pend_r && out_free_s) begin
        m_tvalid <= 1'b1;
        m_tdata  <= pend_data_r;
        m_tstrb  <= pend_strb_r;
        m_tlast  <= 1'b1;
        m_tuser  <= tuser_r;
        pend_r   <= 1'b0;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (pend_set_s) begin
        pend_r      <= 1'b1;
        pend_data_r <= pend_data_s;
        pend_strb_r <= lstrb_s;
      end
    end
  end

endmodule

// File: tb/tb_fifo2axi_repack.sv
// Scoreboard bench for fifo2axi_repack: packets are sliced into 24-byte words,
// expected 32-byte beats are queued, and a monitor checks every accepted beat.
module tb_fifo2axi_repack;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [201:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic         err_phase;

  int    errors = 0;
  int    checks = 0;
  int    err_seen = 0;
  int    err_exp = 0;
  int    tready_mode = 1;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  fifo2axi_repack dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .err_phase(err_phase)
  );

  // Downstream ready: 0 = held low, 1 = held high, otherwise toggles every clock.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = ~m_tready;
      endcase
    end
  end

  // Monitor: beat scoreboard, stall stability and err_phase pulse counting.
  initial begin
    beat_t e;
    beat_t prev;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!m_tvalid || m_tdata !== prev.data || m_tstrb !== prev.strb ||
              m_tuser !== prev.user || m_tlast !== prev.last) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h strb=%h last=%b, expected valid=1 data=%h strb=%h last=%b",
                     m_tvalid, m_tdata, m_tstrb, m_tlast, prev.data, prev.strb, prev.last);
          end
        end
        if (err_phase) err_seen++;
        if (m_tvalid && m_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%h strb=%h last=%b, expected no beat", m_tdata, m_tstrb, m_tlast);
          end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.data || m_tstrb !== e.strb || m_tuser !== e.user || m_tlast !== e.last) begin
              errors++;
              $display("FAIL beat: got data=%h strb=%h user=%h last=%b, expected data=%h strb=%h user=%h last=%b",
                       m_tdata, m_tstrb, m_tuser, m_tlast, e.data, e.strb, e.user, e.last);
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev = {m_tdata, m_tstrb, m_tuser, m_tlast};
      end
    end
  end

  function automatic logic [201:0] mk_word(input logic [191:0] p, input logic [4:0] n,
                                           input logic [2:0] ph, input logic tl);
    return {p, n, ph, tl, 1'b0};
  endfunction

  task automatic send_word(input logic [201:0] w);
    int t;
    din = w;
    din_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL din_ready_timeout: got din_ready=0 for %0d cycles, expected 1", t);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // Byte i of the packet is base+i; bytes past len in the last word are junk (EE).
  task automatic send_packet(input logic [127:0] user, input int len, input logic [7:0] base,
                             input int max_words, input bit expect_beats);
    logic [7:0]   stream [0:191];
    logic [191:0] p;
    beat_t        b;
    int           nbeats;
    int           nwords;
    int           nlast;
    int           idx;
    for (int i = 0; i < 192; i++) stream[i] = (i < len) ? 8'(base + i) : 8'hEE;
    nbeats = (len + 31) / 32;
    nwords = (len + 23) / 24;
    nlast  = len - 32 * (nbeats - 1);
    if (expect_beats) begin
      for (int j = 0; j < nbeats; j++) begin
        for (int bb = 0; bb < 32; bb++) begin
          idx = 32 * j + bb;
          b.data[8*bb +: 8] = (idx < len) ? stream[idx] : 8'h00;
          b.strb[bb] = (idx < len);
        end
        b.user = user;
        b.last = (j == nbeats - 1);
        exp_q.push_back(b);
      end
    end
    send_word(mk_word({64'hDEAD_BEEF_0BAD_F00D, user}, 5'd0, 3'd0, 1'b0));
    for (int k = 0; k < nwords && k < max_words; k++) begin
      for (int bb = 0; bb < 24; bb++) p[8*bb +: 8] = stream[24*k + bb];
      send_word(mk_word(p, (k == nwords - 1) ? 5'(nlast % 32) : 5'd0, 3'(k % 4 + 1), (k == nwords - 1)));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 256'h0 || m_tstrb !== 32'h0 ||
        m_tuser !== 128'h0 || err_phase !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b strb=%h err=%b, expected all zero",
               m_tvalid, m_tlast, m_tstrb, err_phase);
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_din_ready: got %b, expected 1", din_ready);
    end
    @(posedge clk);
    #1;

    // Single-word packet, 20 valid bytes.
    send_packet(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5, 20, 8'h00, 8, 1'b1);
    // Four words, full 96 bytes, three beats.
    send_packet(128'h1111_2222_3333_4444_5555_6666_7777_88A5, 96, 8'h00, 8, 1'b1);
    // P2-terminated packet: tail beat follows back to back, input stalls one clock.
    send_packet(128'h0000_0000_0000_0000_0000_0000_0000_0003, 48, 8'h40, 8, 1'b1);
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b0 || m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL tail_stall: got din_ready=%b valid=%b, expected din_ready=0 valid=1", din_ready, m_tvalid);
    end
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1 || m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL tail_release: got din_ready=%b valid=%b, expected din_ready=1 valid=1", din_ready, m_tvalid);
    end
    @(posedge clk);
    #1;

    // Eight-word packet with ready toggling every clock.
    tready_mode = 2;
    send_packet(128'h4444_0000_0000_0000_0000_0000_0000_0004, 192, 8'h80, 8, 1'b1);
    wait_drain();
    tready_mode = 1;

    // Phase 3 where phase 2 is expected, then stray words until the next header.
    send_word(mk_word({64'h0, 128'h5555}, 5'd0, 3'd0, 1'b0));
    send_word(mk_word({24{8'h5A}}, 5'd0, 3'd1, 1'b0));
    err_exp = 1;
    send_word(mk_word({24{8'h5B}}, 5'd0, 3'd3, 1'b0));
    send_word(mk_word({24{8'h5C}}, 5'd0, 3'd4, 1'b0));
    send_word(mk_word({24{8'h5D}}, 5'd0, 3'd1, 1'b0));
    send_packet(128'h6666_0000_0000_0000_0000_0000_0000_0006, 72, 8'h10, 8, 1'b1);
    wait_drain();

    // Reset after the P2 word of a packet whose first beat is still stalled.
    tready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_packet(128'h7777_0000_0000_0000_0000_0000_0000_0007, 96, 8'h20, 2, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b din_ready=%b, expected valid=0 din_ready=1", m_tvalid, din_ready);
    end
    @(posedge clk);
    #1;
    tready_mode = 1;
    send_packet(128'h8888_0000_0000_0000_0000_0000_0000_0008, 90, 8'h30, 8, 1'b1);
    wait_drain();

    checks++;
    if (err_seen != err_exp) begin
      errors++;
      $display("FAIL err_phase_cycles: got %0d, expected %0d", err_seen, err_exp);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
